// File: rtl/lock_controller.sv
// ============================================================================
//  Module      : lock_controller
//  Description : Sequencing controller for a two-button digital lock.
//                Collects b0/b1 symbols and compares them against a
//                reprogrammable code. A correct entry drives a timed
//                unlock pulse. Consecutive failures are counted, and an
//                optional lockout window can follow too many failures.
//                Optional feature macro: LOCK_LOCKOUT_EN (adds the LOCKOUT
//                state and its timer; when undefined locked_out is tied 0).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_controller #(
    parameter int                  CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  UNLOCK_CYCLES  = 8,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b0,
    input  logic       b1,
    input  logic       prog,
    output logic       unlock,
    output logic       locked_out,
    output logic       prog_mode,
    output logic [3:0] fail_cnt,
    output logic [4:0] entry_cnt
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CHECK   = 3'd1;
    localparam logic [2:0] c_OPEN    = 3'd2;
    localparam logic [2:0] c_PROG    = 3'd3;
`ifdef LOCK_LOCKOUT_EN
    localparam logic [2:0] c_LOCKOUT = 3'd4;
`endif

    // One shared timer serves both the unlock and the lockout windows.
    localparam int c_TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0] c_UNLOCK_LAST  = c_TMR_W'(UNLOCK_CYCLES - 1);
`ifdef LOCK_LOCKOUT_EN
    localparam logic [c_TMR_W-1:0] c_LOCKOUT_LAST = c_TMR_W'(LOCKOUT_CYCLES - 1);
`endif
    localparam logic [4:0] c_LEN       = 5'(CODE_LEN);
    localparam logic [4:0] c_LEN_M1    = 5'(CODE_LEN - 1);
    localparam logic [3:0] c_MAX_FAILS = 4'(MAX_FAILS);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [CODE_LEN-1:0] r_entry;
    logic [CODE_LEN-1:0] r_code;
    logic [4:0]          r_entry_cnt;
    logic [3:0]          r_fail_cnt;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_unlock;
    logic                r_prog_mode;

    // Exactly one button pressed is a symbol; both pressed is an abort.
    logic       w_sym_valid;
    logic       w_abort;
    logic       w_match;
    logic [3:0] w_fail_next;

    assign w_sym_valid = b0 ^ b1;
    assign w_abort     = b0 & b1;
    assign w_match     = (r_entry == r_code);
    assign w_fail_next = (r_fail_cnt == c_MAX_FAILS) ? r_fail_cnt : r_fail_cnt + 4'd1;

    // Next-state decision; outputs are registered from this so they track the state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_sym_valid && (r_entry_cnt == c_LEN_M1))
                    w_next_state = c_CHECK;
            end
            c_CHECK: begin
                if (w_match)
                    w_next_state = c_OPEN;
`ifdef LOCK_LOCKOUT_EN
                else if (w_fail_next == c_MAX_FAILS)
                    w_next_state = c_LOCKOUT;
`endif
                else
                    w_next_state = c_IDLE;
            end
            c_OPEN: begin
                if (prog)
                    w_next_state = c_PROG;
                else if (r_timer == c_UNLOCK_LAST)
                    w_next_state = c_IDLE;
            end
            c_PROG: begin
                // A full code spends one extra cycle here to commit it.
                if ((r_entry_cnt == c_LEN) || w_abort)
                    w_next_state = c_IDLE;
            end
`ifdef LOCK_LOCKOUT_EN
            c_LOCKOUT: begin
                if (r_timer == c_LOCKOUT_LAST)
                    w_next_state = c_IDLE;
            end
`endif
            default: w_next_state = c_IDLE;
        endcase
    end

    // State register, entry shifter, stored code and failure counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_entry     <= '0;
            r_code      <= DEFAULT_CODE;
            r_entry_cnt <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (w_abort) begin
                        r_entry     <= '0;
                        r_entry_cnt <= '0;
                    end else if (w_sym_valid) begin
                        r_entry     <= {r_entry[CODE_LEN-2:0], b1};
                        r_entry_cnt <= r_entry_cnt + 5'd1;
                    end
                end
                c_CHECK: begin
                    r_entry     <= '0;
                    r_entry_cnt <= '0;
                    r_fail_cnt  <= w_match ? 4'd0 : w_fail_next;
                end
                c_OPEN: begin
                    if (prog) begin
                        r_entry     <= '0;
                        r_entry_cnt <= '0;
                    end
                end
                c_PROG: begin
                    if (r_entry_cnt == c_LEN) begin
                        r_code      <= r_entry;
                        r_entry     <= '0;
                        r_entry_cnt <= '0;
                    end else if (w_abort) begin
                        r_entry     <= '0;
                        r_entry_cnt <= '0;
                    end else if (w_sym_valid) begin
                        r_entry     <= {r_entry[CODE_LEN-2:0], b1};
                        r_entry_cnt <= r_entry_cnt + 5'd1;
                    end
                end
`ifdef LOCK_LOCKOUT_EN
                c_LOCKOUT: begin
                    if (r_timer == c_LOCKOUT_LAST)
                        r_fail_cnt <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

    // Window timer restarts on every state change and runs in timed states.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_next_state != r_state) begin
            r_timer <= '0;
        end else if (r_state == c_OPEN
`ifdef LOCK_LOCKOUT_EN
                     || r_state == c_LOCKOUT
`endif
                    ) begin
            r_timer <= r_timer + c_TMR_W'(1);
        end
    end

    // Registered status outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_unlock    <= 1'b0;
            r_prog_mode <= 1'b0;
        end else begin
            r_unlock    <= (w_next_state == c_OPEN) || (w_next_state == c_PROG);
            r_prog_mode <= (w_next_state == c_PROG);
        end
    end

`ifdef LOCK_LOCKOUT_EN
    logic r_locked_out;

    // Lockout indicator follows the upcoming state like the other outputs.
    always_ff @(posedge clk) begin
        if (!reset)
            r_locked_out <= 1'b0;
        else
            r_locked_out <= (w_next_state == c_LOCKOUT);
    end

    assign locked_out = r_locked_out;
`else
    assign locked_out = 1'b0;
`endif

    assign unlock    = r_unlock;
    assign prog_mode = r_prog_mode;
    assign fail_cnt  = r_fail_cnt;
    assign entry_cnt = r_entry_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lock_controller.sv
// ============================================================================
//  Module      : tb_lock_controller
//  Description : Self-checking bench for lock_controller. A transaction-level
//                model keeps the stored code and the failure count; each
//                entry, programming session, abort and reset predicts the
//                cycle-by-cycle outputs from those two quantities.
//                Honours LOCK_LOCKOUT_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_controller;

    localparam logic [4:0] c_DEFAULT   = 5'b01011;
    localparam int         c_MAX_FAILS = 3;
    localparam int         c_UNLOCK    = 8;
    localparam int         c_LOCKOUT   = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       b0    = 1'b0;
    logic       b1    = 1'b0;
    logic       prog  = 1'b0;
    logic       unlock;
    logic       locked_out;
    logic       prog_mode;
    logic [3:0] fail_cnt;
    logic [4:0] entry_cnt;

    int         n_vec   = 0;
    int         n_err   = 0;
    logic [4:0] m_code  = c_DEFAULT;
    int         m_fails = 0;
    bit         ok;

    lock_controller dut (
        .clk        (clk),
        .reset      (reset),
        .b0         (b0),
        .b1         (b1),
        .prog       (prog),
        .unlock     (unlock),
        .locked_out (locked_out),
        .prog_mode  (prog_mode),
        .fail_cnt   (fail_cnt),
        .entry_cnt  (entry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic a, input logic b, input logic p);
        b0   = a;
        b1   = b;
        prog = p;
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic v);
        step(~v, v, 1'b0);
    endtask

    // Symbol or nothing; never an abort, never prog.
    task automatic rand_sym_step();
        int r = $urandom_range(0, 2);
        step(r == 0, r == 1, 1'b0);
    endtask

    task automatic rand_any_step();
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rand_any_step();
        check_val("rst_unlock",     unlock,     0);
        check_val("rst_locked_out", locked_out, 0);
        check_val("rst_prog_mode",  prog_mode,  0);
        check_val("rst_fail_cnt",   fail_cnt,   0);
        check_val("rst_entry_cnt",  entry_cnt,  0);
        reset   = 1'b1;
        m_code  = c_DEFAULT;
        m_fails = 0;
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) begin
            sym(1'($urandom_range(0, 1)));
            check_val("part_cnt", entry_cnt, i + 1);
        end
    endtask

    task automatic abort_entry(input int n);
        partial(n);
        step(1'b1, 1'b1, 1'b0);
        check_val("abort_cnt",    entry_cnt, 0);
        check_val("abort_fails",  fail_cnt,  m_fails);
        check_val("abort_unlock", unlock,    0);
    endtask

    // Full code entry plus the compare cycle; ok says whether it opened.
    task automatic enter(input logic [4:0] code, output bit opened);
        for (int i = 0; i < 5; i++) begin
            int g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                check_val("gap_cnt", entry_cnt, i);
            end
            sym(code[4-i]);
            check_val("entry_cnt",   entry_cnt, i + 1);
            check_val("entry_no_ul", unlock,    0);
        end
        // Compare cycle: whatever is presented here is dropped.
        rand_any_step();
        check_val("chk_cnt", entry_cnt, 0);
        opened = (code == m_code);
        if (opened) begin
            m_fails = 0;
            check_val("open_rise", unlock,     1);
            check_val("open_fail", fail_cnt,   0);
            check_val("open_lo",   locked_out, 0);
        end else begin
            if (m_fails < c_MAX_FAILS)
                m_fails++;
            check_val("bad_fail_cnt", fail_cnt, m_fails);
            check_val("bad_unlock",   unlock,   0);
`ifdef LOCK_LOCKOUT_EN
            if (m_fails == c_MAX_FAILS) begin
                check_val("lockout_on", locked_out, 1);
                for (int k = 1; k < c_LOCKOUT; k++) begin
                    rand_any_step();
                    check_val("lockout_hold", locked_out, 1);
                    check_val("lockout_cnt",  entry_cnt,  0);
                    check_val("lockout_fail", fail_cnt,   c_MAX_FAILS);
                end
                rand_any_step();
                check_val("lockout_off",  locked_out, 0);
                check_val("lockout_clr",  fail_cnt,   0);
                check_val("lockout_drop", entry_cnt,  0);
                m_fails = 0;
            end else begin
                check_val("no_lockout", locked_out, 0);
            end
`else
            check_val("no_lockout", locked_out, 0);
`endif
        end
    endtask

    // Programming session; abort_at=i aborts just before symbol i (1..5).
    task automatic run_prog(input logic [4:0] newc, input int abort_at);
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b0, 1'b0, 1'b0);
                check_val("prog_gap_cnt", entry_cnt, i);
                check_val("prog_gap_pm",  prog_mode, 1);
            end
            if (abort_at == i + 1) begin
                step(1'b1, 1'b1, 1'b0);
                check_val("prog_abort_pm",  prog_mode, 0);
                check_val("prog_abort_ul",  unlock,    0);
                check_val("prog_abort_cnt", entry_cnt, 0);
                return;
            end
            sym(newc[4-i]);
            check_val("prog_cnt", entry_cnt, i + 1);
            check_val("prog_pm",  prog_mode, 1);
            check_val("prog_ul",  unlock,    1);
        end
        step(1'b0, 1'b0, 1'b0);
        check_val("prog_done_ul",  unlock,    0);
        check_val("prog_done_pm",  prog_mode, 0);
        check_val("prog_done_cnt", entry_cnt, 0);
        m_code = newc;
    endtask

    // Unlock window; prog_at=j raises prog on window edge j (0 = never).
    task automatic run_open(input int prog_at, input logic [4:0] newc, input int abort_at);
        for (int j = 1; j <= c_UNLOCK; j++) begin
            if (j == prog_at) begin
                step(1'b0, 1'b0, 1'b1);
                check_val("prog_enter_pm",  prog_mode, 1);
                check_val("prog_enter_ul",  unlock,    1);
                check_val("prog_enter_cnt", entry_cnt, 0);
                run_prog(newc, abort_at);
                return;
            end
            rand_sym_step();
            check_val("open_ul",  unlock,    (j < c_UNLOCK) ? 1 : 0);
            check_val("open_cnt", entry_cnt, 0);
            check_val("open_pm",  prog_mode, 0);
        end
    endtask

    task automatic attempt(input logic [4:0] code, input int prog_at, input logic [4:0] newc,
                           input int abort_at);
        bit opened;
        enter(code, opened);
        if (opened)
            run_open(prog_at, newc, abort_at);
    endtask

    initial begin
        do_reset();

        // Default code opens for the full window.
        attempt(c_DEFAULT, 0, 5'd0, 0);

        // Three wrong entries, then the right one.
        repeat (3) attempt(5'b11111, 0, 5'd0, 0);
        attempt(c_DEFAULT, 0, 5'd0, 0);

        // Abort mid-entry, then a correct entry.
        abort_entry(3);
        attempt(c_DEFAULT, 0, 5'd0, 0);

        // Reprogram to 10010; old code fails, new code opens.
        attempt(c_DEFAULT, 3, 5'b10010, 0);
        attempt(c_DEFAULT, 0, 5'd0, 0);
        attempt(5'b10010, 0, 5'd0, 0);

        // prog on the expiry edge wins; abort keeps the old code.
        attempt(5'b10010, c_UNLOCK, 5'b00110, 2);
        attempt(5'b10010, 0, 5'd0, 0);

        // Reset mid-entry restores the default code.
        partial(3);
        do_reset();
        attempt(5'b10010, 0, 5'd0, 0);
        attempt(c_DEFAULT, 0, 5'd0, 0);

        // Reset mid-window.
        enter(c_DEFAULT, ok);
        repeat (2) begin
            rand_sym_step();
            check_val("mid_open_ul", unlock, 1);
        end
        do_reset();

        // Failures saturate; a correct entry still opens afterwards.
        repeat (5) attempt(5'b11111, 0, 5'd0, 0);
        attempt(c_DEFAULT, 0, 5'd0, 0);

        // Randomized mix of transactions.
        repeat (40) begin
            case ($urandom_range(0, 5))
                0, 1: attempt(m_code,
                              ($urandom_range(0, 1) == 1) ? $urandom_range(1, c_UNLOCK) : 0,
                              5'($urandom_range(0, 31)),
                              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0);
                2: attempt(5'($urandom_range(0, 31)), 0, 5'd0, 0);
                3: abort_entry($urandom_range(0, 4));
                4: begin
                    partial($urandom_range(0, 4));
                    do_reset();
                end
                default: begin
                    enter(m_code, ok);
                    repeat ($urandom_range(0, 6)) begin
                        rand_sym_step();
                        check_val("rnd_open_ul", unlock, 1);
                    end
                    do_reset();
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lock_controller.md
# lock_controller

Sequencing controller for the two-button digital lock.
- Collects b0/b1 symbol entries and compares them against a stored, reprogrammable code.
- Drives a timed `unlock` pulse on a correct entry.
- Counts failed attempts and enforces a lockout window after too many failures.
- Sits between the button inputs and the door actuator; it is the single owner of lock state.

## Interface

- `CODE_LEN`, 5, number of symbols per code (2..16)
- `DEFAULT_CODE`, 5'b01011, code loaded at reset; entered MSB first
- `MAX_FAILS`, 3, consecutive failures that trigger lockout (1..15)
- `UNLOCK_CYCLES`, 8, cycles `unlock` stays high (≥1)
- `LOCKOUT_CYCLES`, 16, cycles inputs are ignored during lockout (≥1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `b0`  in  1  button "0"; a cycle with b0=1, b1=0 is symbol 0
- `b1`  in  1  button "1"; a cycle with b1=1, b0=0 is symbol 1
- `prog`  in  1  while open, request to reprogram the code
- `unlock`  out  1  lock released
- `locked_out`  out  1  lockout window active
- `prog_mode`  out  1  new code being entered
- `fail_cnt`  out  4  consecutive failed attempts
- `entry_cnt`  out  5  symbols collected in the current entry

## Operation

- On reset (`reset`=0 at a clock edge):
  - state=IDLE; code register=`DEFAULT_CODE`.
  - `unlock`, `locked_out`, and `prog_mode` are 0; `fail_cnt`=0; `entry_cnt`=0.
- Symbol decode:
  - b0 xor b1 gives one symbol per cycle.
  - b0=b1=0 means no input.
  - b0=b1=1 means abort: it clears the entry shift register and `entry_cnt`, and is not counted as a fail.
- States:
  - IDLE: each symbol shifts into the entry register (LSB in) and increments `entry_cnt`. When `entry_cnt` reaches `CODE_LEN`, go to CHECK.
  - CHECK (1 cycle; inputs ignored): compare entry against code.
    - Match: `fail_cnt`←0, go to OPEN.
    - Mismatch: `fail_cnt`+1. If the new value equals `MAX_FAILS`, go to LOCKOUT; otherwise go to IDLE.
    - Both outcomes clear `entry_cnt`.
  - OPEN: `unlock`=1 and a timer counts `UNLOCK_CYCLES`. Symbols are ignored.
    - `prog`=1 goes to PROG (takes priority over timer expiry in the same cycle).
    - On expiry, go to IDLE.
  - PROG: `prog_mode`=1, `unlock`=1. Symbols shift into the entry register. After `CODE_LEN` symbols, the code register←entry, then go to IDLE (`unlock`=0).
    - Abort (both buttons) leaves the old code unchanged and goes to IDLE.
  - LOCKOUT: `locked_out`=1; all inputs ignored for `LOCKOUT_CYCLES`. Then `fail_cnt`←0 and go to IDLE.
- `fail_cnt` saturates at `MAX_FAILS` and never wraps.
- A reset in any state, mid-entry or mid-timer, returns to reset values. A programmed code is lost and `DEFAULT_CODE` is restored.

## Timing

- Outputs are registered and reflect the state after each edge.
- Last symbol sampled at edge k → CHECK during cycle k..k+1 → `unlock` rises at edge k+1 and falls at edge k+1+`UNLOCK_CYCLES`.
- A symbol presented during CHECK is dropped and not queued.
- Abort takes effect at the same edge it is sampled.
- LOCKOUT is entered at edge k+1. `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles. The first symbol accepted is at the edge after `locked_out` falls.
- PROG completion: the new code is usable for the very next entry; `unlock` falls at the edge where the last program symbol is sampled plus one.

## Configuration

- `LOCK_LOCKOUT_EN` defined: LOCKOUT state and timer are present, behaving as described above.
- Not defined:
  - No LOCKOUT state or timer; `locked_out` is tied to 0.
  - A mismatch increments `fail_cnt` (saturating at `MAX_FAILS`) and returns to IDLE.
  - A match still clears `fail_cnt`.

## Test plan

- Reset, then symbols 0,1,0,1,1 on consecutive edges → `unlock`=1 for exactly 8 cycles starting 1 edge after the 5th symbol; `fail_cnt`=0.
- Entry 1,1,1,1,1 three times (`LOCK_LOCKOUT_EN` defined) → `fail_cnt` goes 1,2,3 → `locked_out`=1 for 16 cycles, symbols ignored → `fail_cnt`=0. Then 0,1,0,1,1 → unlock.
- Symbols 0,1,0, then b0=b1=1, then 0,1,0,1,1 → `entry_cnt` returns to 0 at the abort; unlock after the second entry; `fail_cnt`=0.
- Correct entry, then `prog`=1 during OPEN, then symbols 1,0,0,1,0 → `prog_mode`=1 while entering. Old code 01011 then fails (`fail_cnt`=1); new code 10010 unlocks.
- Assert `reset`=0 mid-entry (after 3 symbols) and separately mid-OPEN → all outputs return to 0 next edge; code is back to 01011.
- Without `LOCK_LOCKOUT_EN`, five wrong entries → `fail_cnt` saturates at 3, `locked_out` stays 0, and the next correct entry unlocks immediately.
